// File: rtl/cordic_pkg.sv
// Shared types and frame packing for the CORDIC result collector.
package cordic_pkg;
    localparam int VAL_W       = 11;
    localparam int FRAME_BYTES = 3;
    localparam int FRAME_W     = 8 * FRAME_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAP_HI,
        ST_CAP_LO,
        ST_SEND
    } cres_state_t;

    // Frame layout, MSB first on the wire: {mode, 0, hi, lo}
    function automatic logic [FRAME_W-1:0] pack_frame(input logic mode,
                                                      input logic [VAL_W-1:0] hi,
                                                      input logic [VAL_W-1:0] lo);
        return {mode, 1'b0, hi, lo};
    endfunction
endpackage

// File: rtl/cordic_frame_ser.sv
// Loads a packed frame and shifts it out MSB byte first over a valid/ready byte stream.
module cordic_frame_ser
    import cordic_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               tx_ready_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    output logic               last_o
);
    localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

    logic [FRAME_W-1:0] frame_q;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         data_q, byte_d;
    logic               valid_q;
    logic               hs;

    assign hs         = valid_q && tx_ready_i;
    assign last_o     = hs && (idx_q == LAST_IDX);
    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;

    always_comb begin
        idx_d = idx_q + 2'd1;
        case (idx_d)
            2'd1:    byte_d = frame_q[15:8];
            2'd2:    byte_d = frame_q[7:0];
            default: byte_d = frame_q[23:16];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            frame_q <= frame_i;
            data_q  <= frame_i[23:16];
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (hs) begin
            // Next byte is presented in the same edge as the handshake: no bubble
            if (idx_q == LAST_IDX) begin
                valid_q <= 1'b0;
            end else begin
                idx_q  <= idx_d;
                data_q <= byte_d;
            end
        end
    end
endmodule

// File: rtl/cordic_result_collector.sv
// Sequences one CORDIC core run: release core, wait for done, capture both results, send a 3-byte frame.
module cordic_result_collector
    import cordic_pkg::*;
#(
    parameter int VAL_W       = cordic_pkg::VAL_W,
    parameter int TIMEOUT_CYC = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_in,
    output logic             core_rst,
    output logic             core_mode,
    output logic             core_out_toggle,
    input  logic [VAL_W-1:0] core_val,
    input  logic             core_done,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             timeout_err
);
    localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

    cres_state_t       state_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic [VAL_W-1:0]  hi_q;
    logic              core_rst_q, mode_q, tog_q, busy_q, terr_q;
    logic              ser_load, ser_last;

    assign core_rst        = core_rst_q;
    assign core_mode       = mode_q;
    assign core_out_toggle = tog_q;
    assign busy            = busy_q;
    assign timeout_err     = terr_q;

    // lo is taken straight from the core into the serializer's frame register
    assign ser_load = (state_q == ST_CAP_LO);

    cordic_frame_ser u_ser (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ser_load),
        .frame_i    (pack_frame(mode_q, hi_q, core_val)),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .last_o     (ser_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            core_rst_q <= 1'b1;
            mode_q     <= 1'b0;
            tog_q      <= 1'b0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
            wcnt_q     <= '0;
            hi_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q     <= mode_in;
                        core_rst_q <= 1'b0;
                        terr_q     <= 1'b0;
                        wcnt_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wcnt_q <= wcnt_q + WCNT_W'(1);
                    if (core_done) begin
                        tog_q   <= 1'b1;
                        state_q <= ST_CAP_HI;
                    end else if (wcnt_q == WCNT_W'(TIMEOUT_CYC)) begin
                        core_rst_q <= 1'b1;
                        terr_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_CAP_HI: begin
                    hi_q    <= core_val;
                    tog_q   <= 1'b0;
                    state_q <= ST_CAP_LO;
                end
                ST_CAP_LO: begin
                    core_rst_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (ser_last) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    core_rst_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_result_collector.sv
// Self-checking bench: behavioural core model plus frame reference computed from the frame rules.
module tb_cordic_result_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode_in = 1'b0;
    logic        core_rst, core_mode, core_out_toggle;
    logic [10:0] core_val;
    logic        core_done;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy, timeout_err;

    int checks = 0;
    int errors = 0;

    // core model: done becomes a sticky level core_lat edges after release from reset
    logic [10:0] out1 = '0, out2 = '0;
    bit          done_en = 1'b1;
    int          core_lat = 5;
    int          ccnt = 0;
    always @(posedge clk) begin
        if (core_rst) ccnt <= 0;
        else if (ccnt < 1000) ccnt <= ccnt + 1;
    end
    assign core_done = done_en && (ccnt >= core_lat);
    assign core_val  = core_out_toggle ? out1 : out2;

    always #5 clk = ~clk;

    cordic_result_collector dut (
        .clk(clk), .rst(rst), .start(start), .mode_in(mode_in),
        .core_rst(core_rst), .core_mode(core_mode), .core_out_toggle(core_out_toggle),
        .core_val(core_val), .core_done(core_done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    // results of the last do_op
    logic [7:0] got [0:2];
    int nb, first_v, vcnt, bad, ncyc;
    bit tmo;
    logic terr_k0;

    function automatic logic [7:0] exp_byte(input logic m, input logic [10:0] h,
                                            input logic [10:0] l, input int i);
        int f;
        f = (int'(m) * 8388608) + (int'(h) * 2048) + int'(l);
        return 8'((f >> (8 * (2 - i))) & 255);
    endfunction

    // Runs one start..idle operation. rmode: 0 ready high, 1 fixed stall pattern, 2 random.
    task automatic do_op(input logic m, input logic [10:0] h, input logic [10:0] l,
                         input int rmode, input bit spam);
        bit pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bit pv, pr;
        logic [7:0] pd;
        int rc;
        out1 = h; out2 = l;
        nb = 0; first_v = -1; vcnt = 0; bad = 0; tmo = 1; ncyc = -1;
        pv = 0; pr = 0; pd = '0; rc = 0;
        @(negedge clk);
        start = 1'b1; mode_in = m; tx_ready = 1'b0;
        for (int k = 0; k <= 300; k++) begin
            @(negedge clk);
            if (k == 0) terr_k0 = timeout_err;
            start   = spam && busy;
            mode_in = spam ? ~m : m;
            if (tx_valid) begin
                if (first_v < 0) first_v = k;
                vcnt++;
                case (rmode)
                    0:       tx_ready = 1'b1;
                    1:       tx_ready = (rc < 6) ? pat[rc] : 1'b1;
                    default: tx_ready = 1'($urandom_range(0, 1));
                endcase
                rc++;
            end else begin
                tx_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (pv && !pr && (!tx_valid || tx_data !== pd)) bad++;
            if (busy && core_mode !== m) bad++;
            if (tx_valid && core_rst !== 1'b1) bad++;
            if (tx_valid && tx_ready) begin
                if (nb < 3) got[nb] = tx_data;
                nb++;
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            if (!busy) begin
                tmo = 0; ncyc = k;
                break;
            end
        end
        start = 1'b0; tx_ready = 1'b0; mode_in = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %b want 1", core_rst); end
        checks++; if (core_mode !== 1'b0) begin errors++; $display("FAIL reset_core_mode got %b want 0", core_mode); end
        checks++; if (core_out_toggle !== 1'b0) begin errors++; $display("FAIL reset_toggle got %b want 0", core_out_toggle); end
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx got v=%b d=%h want 0/00", tx_valid, tx_data); end
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b terr=%b want 0/0", busy, timeout_err); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_frame(input string nm, input logic m, input logic [10:0] h, input logic [10:0] l);
        checks++;
        if (tmo || nb !== 3) begin
            errors++; $display("FAIL %s_count got %0d bytes tmo=%0d want 3", nm, nb, tmo);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp_byte(m, h, l, i)) begin
                    errors++; $display("FAIL %s_byte%0d got %h want %h", nm, i, got[i], exp_byte(m, h, l, i));
                end
            end
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL %s_protocol got %0d violations want 0", nm, bad); end
    endtask

    task automatic test_rotation_zero;
        core_lat = 5; done_en = 1;
        do_op(1'b0, 11'h000, 11'h13D, 0, 0);
        check_frame("rot0", 1'b0, 11'h000, 11'h13D);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rot0_busy_end got %b want 0", busy); end
    endtask

    task automatic test_rotation_90;
        core_lat = 5;
        do_op(1'b0, 11'd511, 11'd0, 0, 0);
        check_frame("rot90", 1'b0, 11'd511, 11'd0);
        checks++; if (first_v !== 8) begin errors++; $display("FAIL rot90_latency got %0d want 8", first_v); end
        checks++; if (vcnt !== 3) begin errors++; $display("FAIL rot90_valid_cycles got %0d want 3", vcnt); end
    endtask

    task automatic test_backpressure;
        core_lat = 5;
        do_op(1'b1, 11'h5A3, 11'h2C7, 1, 0);
        check_frame("bp", 1'b1, 11'h5A3, 11'h2C7);
        // stall pattern 0,0,1,0,1,1 keeps valid up for 6 cycles
        checks++; if (vcnt !== 6) begin errors++; $display("FAIL bp_valid_cycles got %0d want 6", vcnt); end
    endtask

    task automatic test_watchdog;
        done_en = 0;
        do_op(1'b1, 11'h111, 11'h222, 0, 0);
        checks++; if (tmo || ncyc < 31 || ncyc > 33) begin errors++; $display("FAIL wd_abort_cycle got %0d want 31..33", ncyc); end
        checks++; if (timeout_err !== 1'b1 || core_rst !== 1'b1) begin errors++; $display("FAIL wd_flags got terr=%b core_rst=%b want 1/1", timeout_err, core_rst); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL wd_no_bytes got %0d want 0", nb); end
        done_en = 1;
        do_op(1'b0, 11'h7FF, 11'h400, 0, 0);
        checks++; if (terr_k0 !== 1'b0) begin errors++; $display("FAIL wd_clear got %b want 0", terr_k0); end
        check_frame("wd_next", 1'b0, 11'h7FF, 11'h400);
    endtask

    task automatic test_start_ignored;
        core_lat = 5;
        do_op(1'b1, 11'h0F0, 11'h70F, 1, 1);
        check_frame("spam", 1'b1, 11'h0F0, 11'h70F);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || core_mode !== 1'b1) begin
                errors++; $display("FAIL spam_idle got busy=%b mode=%b want 0/1", busy, core_mode);
            end
        end
    endtask

    task automatic test_mid_reset;
        bit seen;
        core_lat = 5; out1 = 11'h321; out2 = 11'h123;
        @(negedge clk);
        start = 1'b1; mode_in = 1'b1;
        @(negedge clk);
        start = 1'b0; tx_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (tx_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL mreset_first_valid got none want valid"); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== exp_byte(1'b1, 11'h321, 11'h123, 1)) begin
            errors++; $display("FAIL mreset_byte1 got v=%b d=%h want 1/%h", tx_valid, tx_data, exp_byte(1'b1, 11'h321, 11'h123, 1));
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0 || core_rst !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mreset_state got v=%b core_rst=%b busy=%b want 0/1/0", tx_valid, core_rst, busy);
        end
        rst = 1'b1; tx_ready = 1'b0;
        do_op(1'b0, 11'h456, 11'h654, 0, 0);
        check_frame("mreset_after", 1'b0, 11'h456, 11'h654);
    endtask

    task automatic test_random;
        logic m;
        logic [10:0] h, l;
        for (int n = 0; n < 8; n++) begin
            m = 1'($urandom_range(0, 1));
            h = 11'($urandom);
            l = 11'($urandom);
            core_lat = $urandom_range(1, 8);
            do_op(m, h, l, 2, 0);
            check_frame("rand", m, h, l);
        end
    endtask

    initial begin
        test_reset();
        test_rotation_zero();
        test_rotation_90();
        test_backpressure();
        test_watchdog();
        test_start_ignored();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
